// File: rtl/sum_accumulator.sv
// Frame accumulator for 5-bit {c,s} results from a 4-bit ripple adder; emits one total per COUNT beats.
// Build option: SUM_ACCUMULATOR_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
//
// state | meaning
// IDLE  | no beats taken for the current frame
// ACCUM | 1..COUNT-1 beats taken
// HOLD  | frame complete, waiting for out_ready
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       s,
    input  logic             c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_C = 4'(COUNT);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic [ACC_W:0]   beat_ext;
    logic [ACC_W:0]   sum_full;
    logic             take;

    assign beat_ext = {{(ACC_W-4){1'b0}}, c, s};
    assign sum_full = {1'b0, acc} + beat_ext;
    assign in_ready = (state != HOLD);
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        out_valid = 1'b0;
        out_sum   = '0;
        out_ovf   = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_nxt   = beat_ext[ACC_W-1:0];
                    cnt_nxt   = 4'd1;
                    ovf_nxt   = 1'b0;
                    state_nxt = (COUNT_C == 4'd1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (take) begin
                    cnt_nxt = cnt + 4'd1;
                    if (sum_full[ACC_W]) begin
                        ovf_nxt = 1'b1;
                    end
`ifdef SUM_ACCUMULATOR_SATURATE_EN
                    // once clamped, every further non-zero beat carries again, so it stays clamped
                    acc_nxt = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
                    acc_nxt = sum_full[ACC_W-1:0];
`endif
                    if (cnt + 4'd1 == COUNT_C) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                out_sum   = acc;
                out_ovf   = ovf;
                if (out_ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed frames then random traffic, two widths side by side.
module tb_sum_accumulator;

    localparam int COUNT = 4;

    logic       clk;
    logic       rst;
    logic [3:0] s;
    logic       c;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready8, out_ovf8, out_valid8;
    logic [7:0] out_sum8;
    logic       in_ready6, out_ovf6, out_valid6;
    logic [5:0] out_sum6;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // reference: true integer sum of the current frame and whether it is being held
    int frame_total = 0;
    int frame_beats = 0;
    bit holding     = 0;

    sum_accumulator #(.COUNT(COUNT), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .s(s), .c(c),
        .in_valid(in_valid), .in_ready(in_ready8),
        .out_sum(out_sum8), .out_ovf(out_ovf8),
        .out_valid(out_valid8), .out_ready(out_ready)
    );

    sum_accumulator #(.COUNT(COUNT), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .s(s), .c(c),
        .in_valid(in_valid), .in_ready(in_ready6),
        .out_sum(out_sum6), .out_ovf(out_ovf6),
        .out_valid(out_valid6), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_sum(input int t, input int w);
        int lim;
        lim = 1 << w;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        return (t >= lim) ? lim - 1 : t;
`else
        return t % lim;
`endif
    endfunction

    function automatic int exp_ovf(input int t, input int w);
        return (t >= (1 << w)) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            frame_total = 0;
            frame_beats = 0;
            holding     = 0;
        end else if (holding) begin
            if (out_ready) begin
                holding     = 0;
                frame_total = 0;
                frame_beats = 0;
            end
        end else if (in_valid) begin
            frame_total += int'({c, s});
            frame_beats++;
            if (frame_beats == COUNT) holding = 1;
        end
    end

    always @(negedge clk) begin
        check("in_ready8", int'(in_ready8), holding ? 0 : 1);
        check("out_valid8", int'(out_valid8), holding ? 1 : 0);
        check("out_sum8", int'(out_sum8), holding ? exp_sum(frame_total, 8) : 0);
        check("out_ovf8", int'(out_ovf8), holding ? exp_ovf(frame_total, 8) : 0);
        check("in_ready6", int'(in_ready6), holding ? 0 : 1);
        check("out_valid6", int'(out_valid6), holding ? 1 : 0);
        check("out_sum6", int'(out_sum6), holding ? exp_sum(frame_total, 6) : 0);
        check("out_ovf6", int'(out_ovf6), holding ? exp_ovf(frame_total, 6) : 0);
    end

    task automatic beat(input logic [4:0] v);
        in_valid = 1'b1;
        {c, s}   = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        {c, s}    = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready8), 1);
        check("rst_out_valid", int'(out_valid8), 0);
        check("rst_out_sum", int'(out_sum8), 0);
        check("rst_out_ovf", int'(out_ovf8), 0);

        // nominal frame; the 6-bit instance overflows on the same beats
        repeat (4) beat(5'd31);
        check("nom_valid", int'(out_valid8), 1);
        check("nom_sum", int'(out_sum8), 124);
        check("nom_ovf", int'(out_ovf8), 0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        check("ovf6_sum", int'(out_sum6), 63);
`else
        check("ovf6_sum", int'(out_sum6), 60);
`endif
        check("ovf6_ovf", int'(out_ovf6), 1);

        // backpressure with a beat offered the whole time
        in_valid = 1'b1;
        {c, s}   = 5'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready8), 0);
            check("bp_sum", int'(out_sum8), 124);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", int'(out_valid8), 0);
        check("bp_release_ready", int'(in_ready8), 1);
        in_valid = 1'b0;

        // gapped frame
        beat(5'd3); idle(1);
        beat(5'd5); idle(2);
        beat(5'd7); idle(1);
        beat(5'd9);
        check("gap_sum", int'(out_sum8), 24);
        check("gap_ovf", int'(out_ovf8), 0);
        check("gap_sum6", int'(out_sum6), 24);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset mid-frame, with a beat offered on the reset edge
        beat(5'd10);
        beat(5'd10);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) beat(5'd1);
        check("midrst_sum", int'(out_sum8), 4);
        check("midrst_ovf", int'(out_ovf8), 0);

        // reset during HOLD overrides a simultaneous handshake
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        check("hold_rst_valid", int'(out_valid8), 0);
        check("hold_rst_sum", int'(out_sum8), 0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            {c, s}    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL provide parameter COUNT, default 4: number of adder results accumulated per output frame, range 1..15.
REQ-002 SHALL provide parameter ACC_W, default 8: accumulator and output width, range 5..16.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port s  input  4  sum bits from the upstream 4-bit ripple adder.
REQ-006 SHALL have port c  input  1  carry-out from the upstream 4-bit ripple adder.
REQ-007 SHALL have port in_valid  input  1  s/c hold a valid result this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts a result this cycle.
REQ-009 SHALL have port out_sum  output  ACC_W  accumulated frame total.
REQ-010 SHALL have port out_ovf  output  1  frame total exceeded the ACC_W range.
REQ-011 SHALL have port out_valid  output  1  out_sum/out_ovf hold a completed frame.
REQ-012 SHALL have port out_ready  input  1  downstream takes the frame this cycle.

Function
REQ-013 SHALL treat each input beat as the 5-bit unsigned value {c,s} (0..31), zero-extended to ACC_W+1 bits before addition.
REQ-014 SHALL accept a beat only on a rising edge where in_valid=1 and in_ready=1; s/c are ignored otherwise.
REQ-015 SHALL implement states IDLE (beat count 0), ACCUM (1..COUNT-1 beats taken), HOLD (frame complete, awaiting output handshake).
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD, as a combinational function of state only.
REQ-017 SHALL, on an accepted beat in IDLE, load the accumulator with the beat value, set the count to 1, set ovf to 0, and go to ACCUM, or to HOLD when COUNT=1.
REQ-018 SHALL, on an accepted beat in ACCUM, add the beat to the accumulator and increment the count; the beat that makes count equal COUNT moves the state to HOLD.
REQ-019 SHALL hold state, count and accumulator unchanged in IDLE or ACCUM on any cycle without an accepted beat.
REQ-020 SHALL assert out_valid=1 exactly while in HOLD, so out_valid rises on the cycle after the final beat is accepted (latency 1 clock).
REQ-021 SHALL keep out_sum and out_ovf stable throughout HOLD.
REQ-022 SHALL leave HOLD for IDLE on the edge where out_ready=1, clearing the count; no beat is accepted on that edge.
REQ-023 SHALL drive out_sum and out_ovf to 0 whenever out_valid=0.
REQ-024 SHALL set ovf when an addition produces a carry beyond ACC_W bits; ovf is sticky until the next frame starts.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE with count=0, accumulator=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0 and in_ready=1 after that edge.
REQ-026 SHALL let rst override any simultaneous beat or output handshake, including reset mid-frame and reset during HOLD; partial frames are discarded.

Configuration
REQ-027 SHALL honour macro SUM_ACCUMULATOR_SATURATE_EN: when defined, an overflowing addition clamps the accumulator to all ones and holds it there for the rest of the frame, with ovf set.
REQ-028 SHALL, when SUM_ACCUMULATOR_SATURATE_EN is undefined, wrap the accumulator modulo 2^ACC_W on overflow, with ovf set.

Verification
REQ-029 SHALL cover reset: assert rst for 2 cycles -> in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-030 SHALL cover a nominal frame: COUNT=4, ACC_W=8, four consecutive beats {c=1,s=1111} -> out_valid rises 1 cycle after the 4th beat, out_sum=124, out_ovf=0.
REQ-031 SHALL cover backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_sum stable, no beat consumed; out_ready=1 -> IDLE next cycle and the next beat starts a new frame.
REQ-032 SHALL cover gapped input: beats 3, 5, 7, 9 with in_valid=0 gaps between them -> out_sum=24, out_ovf=0.
REQ-033 SHALL cover overflow: ACC_W=6, four beats of 31 -> out_sum=60, out_ovf=1 without SUM_ACCUMULATOR_SATURATE_EN; out_sum=63, out_ovf=1 with it.
REQ-034 SHALL cover mid-frame reset: two beats of 10, then rst, then four beats of 1 -> out_sum=4, out_ovf=0.
